// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Grant-state enum, requester count, select width and a one-hot helper.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;
    localparam int CNT_W   = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set req bit searching ptr, ptr+1, ... mod 8.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [SEL_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] req,
    output logic [SEL_W-1:0]   idx,
    output logic               valid
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the nearest hit to ptr wins last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with a bounded hold time and a mandatory idle gap
// between grants; all outputs are driven straight from flops.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               timeout,
    output arb_state_t         state_dbg
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t         state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic [SEL_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               rel_norm;
    logic               rel_expire;

    rr_pick8 u_pick (
        .ptr   (ptr_q),
        .req   (req),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    // A normal release wins over hold-limit expiry when both happen together.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
        rel_norm   = 1'b0;
        rel_expire = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (pick_valid) begin
                    state_d = ARB_BUSY;
                    sel_d   = pick_idx;
                end
            end
            ARB_BUSY: begin
                rel_norm   = done[sel_q] | ~req[sel_q];
                rel_expire = (cnt_q == HOLD_LAST);
                if (rel_norm || rel_expire) begin
                    state_d   = ARB_IDLE;
                    ptr_d     = sel_q + 3'd1;
                    cnt_d     = '0;
                    timeout_d = rel_expire & ~rel_norm;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_d  = (state_d == ARB_BUSY) ? onehot(sel_d) : '0;
        busy_d = (state_d == ARB_BUSY);
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter8;
    import arb_pkg::*;

    localparam int MH = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] req;
    logic [7:0] done;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;
    arb_state_t state_dbg;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: current owner (-1 = none), search pointer, last owner,
    // cycles held so far, and the pending timeout flag.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_last  = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] prev_gnt = 8'h00;
    bit         sb_en = 1'b0;

    rr_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy),
        .timeout   (timeout),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_last  = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_step();
        bit norm;
        bit lim;
        int i;
        if (m_owner >= 0) begin
            norm = done[m_owner] || !req[m_owner];
            lim  = (m_held == MH - 1);
            if (norm || lim) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_held  = 0;
                m_to    = lim && !norm;
            end else begin
                m_held = m_held + 1;
            end
        end else begin
            m_to = 1'b0;
            for (int k = 0; k < 8; k++) begin
                i = (m_ptr + k) % 8;
                if (req[i]) begin
                    m_owner = i;
                    m_last  = i;
                    m_held  = 0;
                    break;
                end
            end
        end
    endfunction

    task automatic check_outputs(input string ph);
        logic [7:0] eg;
        eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        check_eq({ph, ".gnt"}, gnt, eg);
        check_eq({ph, ".sel"}, {5'b0, sel}, 8'(m_last));
        check_eq({ph, ".busy"}, {7'b0, busy}, (m_owner >= 0) ? 8'd1 : 8'd0);
        check_eq({ph, ".timeout"}, {7'b0, timeout}, {7'b0, m_to});
        check_eq({ph, ".state"}, {7'b0, state_dbg}, (m_owner >= 0) ? 8'd1 : 8'd0);
        if (sb_en && gnt != 8'h00 && prev_gnt == 8'h00) begin
            if (exp_q.size() == 0) check_eq("sb.extra", gnt, 8'h00);
            else                   check_eq("sb.order", gnt, exp_q.pop_front());
        end
        prev_gnt = gnt;
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_step();
        #1;
        check_outputs(ph);
        @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] d, input string ph);
        req  = r;
        done = d;
        tick(ph);
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 8'hFF;
        done    = 8'h00;
        model_reset();
        #1;
        check_outputs("rst_async");
        repeat (3) tick("rst_hold");

        reset_n = 1'b1;
        tick("rst_rel");
        check_eq("first_gnt", gnt, 8'h01);
        check_eq("first_sel", {5'b0, sel}, 8'h00);

        // Full rotation with one-cycle holds.
        for (int i = 1; i < 8; i++) exp_q.push_back(8'(1 << i));
        exp_q.push_back(8'h01);
        sb_en    = 1'b1;
        prev_gnt = gnt;
        for (int i = 0; i < 16; i++)
            drive(8'hFF, (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00, "rr");
        check_eq("sb.drain", 8'(exp_q.size()), 8'h00);
        sb_en = 1'b0;
        drive(8'hFF, 8'h01, "rr_end");

        // Hold-limit expiry on owner 3 with requester 4 waiting.
        drive(8'h18, 8'h00, "hl_gnt");
        check_eq("hl_gnt3", gnt, 8'h08);
        repeat (MH - 1) drive(8'h18, 8'h00, "hl_hold");
        check_eq("hl_still3", gnt, 8'h08);
        drive(8'h18, 8'h00, "hl_exp");
        check_eq("hl_drop", gnt, 8'h00);
        check_eq("hl_to", {7'b0, timeout}, 8'h01);
        drive(8'h18, 8'h00, "hl_next");
        check_eq("hl_gnt4", gnt, 8'h10);
        check_eq("hl_sel4", {5'b0, sel}, 8'h04);
        check_eq("hl_to_clr", {7'b0, timeout}, 8'h00);
        drive(8'h10, 8'h10, "hl_rel");

        // Wrap after owner 7, then non-owner done ignored.
        drive(8'h80, 8'h00, "w7");
        drive(8'h80, 8'h80, "w7_rel");
        drive(8'h41, 8'h00, "w_g0");
        check_eq("wrap_g0", gnt, 8'h01);
        drive(8'h41, 8'h01, "w_r0");
        drive(8'h41, 8'h00, "w_g6");
        check_eq("wrap_g6", gnt, 8'h40);
        drive(8'h41, 8'h40, "w_r6");
        drive(8'h04, 8'h00, "o2");
        for (int i = 0; i < 4; i++) begin
            drive(8'h04, 8'h10, "o2_ign");
            check_eq("o2_hold", gnt, 8'h04);
        end
        drive(8'h04, 8'h04, "o2_rel");

        // done on the last hold cycle counts as a normal release.
        drive(8'h20, 8'h00, "co_gnt");
        repeat (MH - 1) drive(8'h20, 8'h00, "co_hold");
        drive(8'h20, 8'h20, "co_rel");
        check_eq("co_drop", gnt, 8'h00);
        check_eq("co_no_to", {7'b0, timeout}, 8'h00);
        drive(8'h00, 8'h00, "co_idle");

        // Asynchronous reset in the middle of a grant.
        drive(8'h01, 8'h00, "am_gnt");
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("am_gnt_drop", gnt, 8'h00);
        model_reset();
        check_outputs("am_async");
        tick("am_hold");
        reset_n = 1'b1;
        drive(8'hFF, 8'h00, "am_restart");
        check_eq("am_restart_g0", gnt, 8'h01);
        drive(8'hFF, 8'h01, "am_rel");

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) req = 8'($urandom_range(0, 255));
            done = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            reset_n = ($urandom_range(0, 99) != 0);
            tick("rnd");
        end
        reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 The parameter MAX_HOLD SHALL default to 16 and set the maximum number of cycles one owner holds the grant (legal range 1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  8  request lines, one per requester; req[i] high = requester i wants the shared 8:1 mux path.
REQ-005 done  input  8  release strobes; only done[owner] is honoured.
REQ-006 gnt  output  8  registered one-hot grant; all-zero when no owner.
REQ-007 sel  output  3  registered binary index of current/last owner; drives the 8:1 mux select.
REQ-008 busy  output  1  high while a grant is held.
REQ-009 timeout  output  1  one-cycle pulse when a grant is revoked by hold-limit expiry.

Function
REQ-010 The FSM SHALL have two states: ARB_IDLE and ARB_BUSY.
REQ-011 ARB_IDLE: gnt=0, busy=0; sel holds the last owner's index.
REQ-012 ARB_IDLE with any req bit high at a clock edge SHALL go to ARB_BUSY on that edge, with gnt/sel/busy registered: latency is one cycle from req sampled to gnt visible.
REQ-013 Winner selection SHALL be round-robin: search starts at ptr and proceeds ptr, ptr+1, ... 7, 0, ... (mod 8); the first set req bit wins.
REQ-014 ptr SHALL become (owner+1) mod 8 on each grant release; 7 wraps to 0.
REQ-015 ARB_BUSY: gnt one-hot at owner, sel=owner, busy=1, hold counter increments by 1 per cycle starting at 0 on the grant cycle.
REQ-016 Release SHALL occur when done[owner]=1, or req[owner]=0, or the hold counter reaches MAX_HOLD-1; on that edge, state goes to ARB_IDLE and gnt goes 0.
REQ-017 Every release SHALL be followed by at least one ARB_IDLE cycle (gnt=0) before the next grant, so that no two owners are ever granted back-to-back without a gap.
REQ-018 timeout SHALL pulse high for exactly the first ARB_IDLE cycle after a hold-limit release, and stays 0 otherwise.
REQ-019 If a normal release (done[owner] or req[owner] low) and hold-limit expiry coincide, the release SHALL count as normal and timeout SHALL stay 0.
REQ-020 done bits of non-owners, and req changes of non-owners, SHALL be ignored during ARB_BUSY.
REQ-021 The hold counter width SHALL be 8 bits; it clears to 0 on entry to ARB_IDLE and never wraps.

Reset
REQ-022 While reset_n=0, the block SHALL drive gnt=0, sel=0, busy=0, timeout=0, ptr=0, counter=0, state=ARB_IDLE, asynchronously and without waiting for a clock edge.
REQ-023 Reset asserted mid-grant SHALL drop gnt immediately; after reset_n rises, arbitration restarts from ptr=0 on the first edge.

Structure
REQ-024 Package arb_pkg SHALL hold typedef arb_state_t {ARB_IDLE, ARB_BUSY}, NUM_REQ=8 and SEL_W=3.
REQ-025 The design SHALL use one combinational sub-module rr_pick8 (inputs ptr[2:0], req[7:0]; outputs idx[2:0], valid), which implements REQ-013.

Verification
REQ-026 Hold reset_n=0 with req=8'hFF, then release reset_n -> gnt=0 during reset; first grant gnt=8'h01, sel=0 one cycle after reset_n rises.
REQ-027 req=8'hFF; each owner pulses done one cycle after its grant -> grant order 0,1,2,...,7,0, with a one-cycle gnt=0 gap between grants.
REQ-028 MAX_HOLD=16; owner 3 holds req without done; req[4]=1 -> gnt drops after 16 busy cycles, timeout=1 for one cycle, next grant gnt=8'h10, sel=4.
REQ-029 Last owner 7, then req=8'h41 -> grant 0 first, then 6; owner 2 busy with done=8'h10 -> ignored, gnt stays 8'h04.
REQ-030 done[owner] pulses on the cycle the counter reaches MAX_HOLD-1 -> release with timeout=0; separately, pull reset_n low mid-grant -> gnt=0 before the next clk edge.
